// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry skid, flush, idle hint.
// Latency 1 cycle; with SKID=1 in_ready is registered, with SKID=0 it is combinational from out_ready.
module pipe_stage_skid #(
  parameter int PAYLOAD_W   = 71,
  parameter int SKID        = 1,
  parameter int IDLE_CYCLES = 8,
  parameter int IDLE_CNT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 flush,
  output logic [1:0]           occupancy,
  output logic                 idle
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_CYCLES);

  logic                 main_valid_q, main_valid_d;
  logic [PAYLOAD_W-1:0] main_data_q,  main_data_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_data_q,  skid_data_d;
  logic                 rdy_q,        rdy_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q,  idle_cnt_d;
  logic                 idle_q,       idle_d;

  logic in_fire;
  logic out_fire;

  // Flush gates in_ready so a killed cycle never accepts a beat.
  assign in_ready  = ((SKID != 0) ? rdy_q : (!main_valid_q || out_ready)) && !flush;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);
  assign idle      = idle_q;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_fire) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // in_ready is low whenever skid holds data, so a load never collides with the skid->main move.
    if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data;
        skid_valid_d = 1'b1;
      end
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end

    rdy_d = !skid_valid_d;

    if (occupancy == 2'd0 && !in_valid) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_CNT_W'(1);
    end else begin
      idle_cnt_d = '0;
    end
    idle_d = (idle_cnt_d == IDLE_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b1;
      idle_cnt_q   <= '0;
      idle_q       <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= rdy_d;
      idle_cnt_q   <= idle_cnt_d;
      idle_q       <= idle_d;
    end
  end

endmodule
